// File: rtl/simd_pkg.sv
// Types shared by the SIMD pipeline stages: instruction word and fetch-buffer states.
package simd_pkg;
  localparam int unsigned IW = 25;

  typedef logic [IW-1:0] instr_t;

  typedef enum logic [1:0] {
    IBUF_IDLE = 2'd0,
    IBUF_RUN  = 2'd1,
    IBUF_DONE = 2'd2
  } ibuf_state_e;
endpackage

// File: rtl/instr_buffer_if.sv
// Host-facing bundle of the instruction buffer: load/control inputs and issue/status outputs.
interface instr_buffer_if #(
  parameter int unsigned DEPTH = 64
);
  import simd_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic          load_en;
  instr_t        load_data;
  logic          clear;
  logic          start;
  logic          stall;
  instr_t        instr_out;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic [AW:0]   count;
  logic          busy;
  logic          done;
  logic          overflow;

  modport master (
    output load_en, load_data, clear, start, stall,
    input  instr_out, instr_valid, pc, count, busy, done, overflow
  );

  modport slave (
    input  load_en, load_data, clear, start, stall,
    output instr_out, instr_valid, pc, count, busy, done, overflow
  );
endinterface

// File: rtl/instr_mem.sv
// Program store: single write port, registered read port; only the read register is reset.
module instr_mem
  import simd_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  instr_t        wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output instr_t        rdata
);
  instr_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register doubles as the issued-instruction register, so it holds when not read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/instr_buffer.sv
// Instruction fetch stage: loads a program serially, then issues it in order with stall support.
module instr_buffer
  import simd_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_buffer_if.slave bus
);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  ibuf_state_e state_q, state_d;
  logic [AW:0] pc_q, pc_d;
  logic [AW:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        ovf_q, ovf_d;
  logic        we, re;
  instr_t      rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IBUF_IDLE;
      pc_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    re      = 1'b0;
    unique case (state_q)
      IBUF_IDLE, IBUF_DONE: begin
        if (bus.clear) begin
          count_d = '0;
          pc_d    = '0;
          ovf_d   = 1'b0;
          state_d = IBUF_IDLE;
        end else if (bus.start) begin
          pc_d    = '0;
          state_d = (count_q != '0) ? IBUF_RUN : IBUF_DONE;
        end else if (bus.load_en && state_q == IBUF_IDLE) begin
          if (count_q != FULL) begin
            we      = 1'b1;
            count_d = count_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      IBUF_RUN: begin
        if (!bus.stall) begin
          if (pc_q < count_q) begin
            re      = 1'b1;
            valid_d = 1'b1;
            pc_d    = pc_q + 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = IBUF_DONE;
          end
        end
      end
      default: state_d = IBUF_IDLE;
    endcase
  end

  instr_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (count_q[AW-1:0]),
    .wdata (bus.load_data),
    .re    (re),
    .raddr (pc_q[AW-1:0]),
    .rdata (rd_data)
  );

  assign bus.instr_out   = rd_data;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q[AW-1:0];
  assign bus.count       = count_q;
  assign bus.busy        = (state_q == IBUF_RUN);
  assign bus.done        = (state_q == IBUF_DONE);
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_instr_buffer.sv
// Bench for instr_buffer: spec-level program model checked every cycle plus directed literal checks.
module tb_instr_buffer;
  import simd_pkg::*;

  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  instr_buffer_if #(.DEPTH(DEPTH)) bus ();

  instr_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model: mode 0=idle 1=run 2=done, program held as a plain array.
  int          m_mode = 0;
  int          m_pc   = 0;
  int          m_cnt  = 0;
  int          m_ovf  = 0;
  int          m_valid = 0;
  logic [31:0] m_out  = '0;
  logic [31:0] m_prog [DEPTH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pc = 0; m_cnt = 0; m_ovf = 0; m_valid = 0; m_out = '0;
    end else if (m_mode == 1) begin
      if (!bus.stall) begin
        if (m_pc < m_cnt) begin
          m_out = m_prog[m_pc]; m_valid = 1; m_pc++;
        end else begin
          m_valid = 0; m_mode = 2;
        end
      end
    end else if (bus.clear) begin
      m_cnt = 0; m_pc = 0; m_ovf = 0; m_mode = 0;
    end else if (bus.start) begin
      m_pc = 0;
      m_mode = (m_cnt > 0) ? 1 : 2;
    end else if (bus.load_en && m_mode == 0) begin
      if (m_cnt < DEPTH) begin
        m_prog[m_cnt] = 32'(bus.load_data); m_cnt++;
      end else begin
        m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    check("instr_out",   32'(bus.instr_out),   m_out);
    check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
    check("pc",          32'(bus.pc),          32'(m_pc % DEPTH));
    check("count",       32'(bus.count),       32'(m_cnt));
    check("busy",        32'(bus.busy),        32'(m_mode == 1));
    check("done",        32'(bus.done),        32'(m_mode == 2));
    check("overflow",    32'(bus.overflow),    32'(m_ovf));
  end

  logic [31:0] seen [$];
  always @(negedge clk) begin
    if (bus.instr_valid === 1'b1) seen.push_back(32'(bus.instr_out));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] v);
    bus.load_en = 1'b1;
    bus.load_data = v[IW-1:0];
    tick();
    bus.load_en = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      if (bus.done === 1'b1) break;
      tick();
    end
    check("done_reached", 32'(bus.done), 32'd1);
  endtask

  initial begin
    bus.load_en = 1'b0; bus.load_data = '0; bus.clear = 1'b0;
    bus.start = 1'b0; bus.stall = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_instr_out", 32'(bus.instr_out), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);

    // Empty start: DONE after the start edge, nothing issued.
    seen.delete();
    do_start();
    check("empty_done", 32'(bus.done), 32'd1);
    check("empty_out", 32'(bus.instr_out), 32'd0);
    tick();
    check("empty_none", 32'(seen.size()), 32'd0);
    do_clear();

    // Basic issue.
    load(32'h0000001); load(32'h1ABCDEF); load(32'h0F0F0F0);
    seen.delete();
    do_start();
    wait_done();
    check("basic_n", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      check("basic_0", seen[0], 32'h0000001);
      check("basic_1", seen[1], 32'h1ABCDEF);
      check("basic_2", seen[2], 32'h0F0F0F0);
    end
    check("basic_busy", 32'(bus.busy), 32'd0);
    check("basic_pc", 32'(bus.pc), 32'd3);

    // Rerun without clear; load pulse during RUN is ignored.
    seen.delete();
    do_start();
    load(32'h1555555);
    wait_done();
    check("rerun_n", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      check("rerun_0", seen[0], 32'h0000001);
      check("rerun_2", seen[2], 32'h0F0F0F0);
    end
    check("rerun_count", 32'(bus.count), 32'd3);
    do_clear();

    // Mid-run stall while the 2nd instruction is on instr_out.
    load(32'h0000A0A); load(32'h0000B0B); load(32'h0000C0C); load(32'h0000D0D);
    seen.delete();
    do_start();
    tick(); tick();
    check("stall_cur", 32'(bus.instr_out), 32'h0000B0B);
    bus.stall = 1'b1;
    tick(); tick();
    check("stall_pc", 32'(bus.pc), 32'd2);
    bus.stall = 1'b0;
    wait_done();
    check("stall_n", 32'(seen.size()), 32'd6);
    if (seen.size() == 6) begin
      check("stall_0", seen[0], 32'h0000A0A);
      check("stall_1", seen[1], 32'h0000B0B);
      check("stall_2", seen[2], 32'h0000B0B);
      check("stall_3", seen[3], 32'h0000B0B);
      check("stall_4", seen[4], 32'h0000C0C);
      check("stall_5", seen[5], 32'h0000D0D);
    end
    do_clear();

    // Overflow: 65 loads into 64 slots.
    for (int i = 0; i < 65; i++) load(32'h100000 + 32'(i));
    check("ovf_count", 32'(bus.count), 32'd64);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    seen.delete();
    do_start();
    wait_done();
    check("ovf_n", 32'(seen.size()), 32'd64);
    if (seen.size() == 64) begin
      check("ovf_first", seen[0], 32'h100000);
      check("ovf_last", seen[63], 32'h10003F);
    end
    do_clear();
    check("clr_count", 32'(bus.count), 32'd0);
    check("clr_ovf", 32'(bus.overflow), 32'd0);

    // Asynchronous reset mid-run.
    load(32'h0000111); load(32'h0000222); load(32'h0000333); load(32'h0000444);
    do_start();
    tick(); tick();
    check("ar_busy_pre", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out", 32'(bus.instr_out), 32'd0);
    check("ar_valid", 32'(bus.instr_valid), 32'd0);
    check("ar_pc", 32'(bus.pc), 32'd0);
    check("ar_count", 32'(bus.count), 32'd0);
    check("ar_flags", {29'd0, bus.busy, bus.done, bus.overflow}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("ar_count_post", 32'(bus.count), 32'd0);
    check("ar_busy_post", 32'(bus.busy), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
